// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions used by the instruction fetch unit: fetch FSM
// encoding and the default address/instruction widths.
package instr_fetch_pkg;

  localparam int unsigned DWIDTH_DEF = 8;
  localparam int unsigned IWIDTH_DEF = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HI    = 2'd1,
    LO    = 2'd2,
    FULL  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Two-beat instruction fetch: reads the big-endian byte pair at pc from a
// byte-wide memory and holds the assembled instruction while pc is unchanged.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int IWIDTH = IWIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] pc,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic [DWIDTH-1:0] mem_addr,
  output logic [IWIDTH-1:0] instr,
  output logic              instr_valid,
  output logic              stall,
  output logic              misaligned
);

  fetch_state_t      state_q, state_d;
  logic [DWIDTH-1:0] tag_q, tag_d;
  logic [DWIDTH-1:0] hi_q, hi_d;
  logic [IWIDTH-1:0] instr_q, instr_d;
  logic              mem_req_q, mem_req_d;
  logic [DWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic              redirect_s;
  logic              lo_s;

  // Next-state, tag, byte capture and next memory request.
  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    hi_d       = hi_q;
    instr_d    = instr_q;
    redirect_s = (pc != tag_q);

    case (state_q)
      EMPTY: begin
        state_d = HI;
        tag_d   = pc;
      end
      HI: begin
        if (mem_ready) begin
          // A redirect still consumes the returned beat, then restarts at pc.
          if (redirect_s) begin
            state_d = HI;
            tag_d   = pc;
          end else begin
            hi_d    = mem_rdata;
            state_d = LO;
          end
        end else begin
          state_d = HI;
        end
      end
      LO: begin
        if (mem_ready) begin
          if (redirect_s) begin
            state_d = HI;
            tag_d   = pc;
          end else begin
            instr_d = {hi_q, mem_rdata};
            state_d = FULL;
          end
        end else begin
          state_d = LO;
        end
      end
      FULL: begin
        if (redirect_s) begin
          state_d = HI;
          tag_d   = pc;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // One adder serves both beats: tag for HI, tag+1 (wrapping) for LO.
    lo_s       = (state_d == LO);
    mem_req_d  = (state_d == HI) || (state_d == LO);
    mem_addr_d = tag_d + {{(DWIDTH-1){1'b0}}, lo_s};
  end

  // FSM and datapath registers; reset abandons any in-flight fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      tag_q      <= {DWIDTH{1'b0}};
      hi_q       <= {DWIDTH{1'b0}};
      instr_q    <= {IWIDTH{1'b0}};
      mem_req_q  <= 1'b0;
      mem_addr_q <= {DWIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      hi_q       <= hi_d;
      instr_q    <= instr_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == FULL) && (pc == tag_q);
  assign stall       = ~instr_valid;
  assign misaligned  = pc[0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: byte-wide memory model and hand-computed
// expectations for each fetch scenario.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic [7:0]  pc;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [15:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        misaligned;

  logic [7:0]  mem_model [256];
  int          checks;
  int          errors;

  instr_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .misaligned  (misaligned)
  );

  assign mem_rdata = mem_model[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
    mem_model[8'h00] = 8'hA1; mem_model[8'h01] = 8'hB2;
    mem_model[8'h10] = 8'hC3; mem_model[8'h11] = 8'hD4;
    mem_model[8'hFF] = 8'h12;
    mem_model[8'h20] = 8'hE5; mem_model[8'h21] = 8'hF6;
    mem_model[8'h40] = 8'h47; mem_model[8'h41] = 8'h48;
    mem_model[8'h30] = 8'h39; mem_model[8'h31] = 8'h3A;
    mem_model[8'h05] = 8'h55; mem_model[8'h06] = 8'h66;

    reset = 1'b1; pc = 8'h00; mem_ready = 1'b1;
    #2;
    chk_eq("rst_req",   {31'd0, mem_req},     32'd0);
    chk_eq("rst_addr",  {24'd0, mem_addr},    32'h00);
    chk_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk_eq("rst_stall", {31'd0, stall},       32'd1);
    chk_eq("rst_instr", {16'd0, instr},       32'h0000);

    // Basic fetch of 00/01 after reset release
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_eq("f0_req_hi",  {31'd0, mem_req},     32'd1);
    chk_eq("f0_addr_hi", {24'd0, mem_addr},    32'h00);
    chk_eq("f0_valid1",  {31'd0, instr_valid}, 32'd0);
    tick();
    chk_eq("f0_addr_lo", {24'd0, mem_addr},    32'h01);
    chk_eq("f0_valid2",  {31'd0, instr_valid}, 32'd0);
    tick();
    chk_eq("f0_valid3",  {31'd0, instr_valid}, 32'd1);
    chk_eq("f0_stall3",  {31'd0, stall},       32'd0);
    chk_eq("f0_req_full",{31'd0, mem_req},     32'd0);
    chk_eq("f0_instr",   {16'd0, instr},       32'hA1B2);

    // pc=10 with two wait cycles in HI
    pc = 8'h10; mem_ready = 1'b0;
    #1;
    chk_eq("w_valid0", {31'd0, instr_valid}, 32'd0);
    chk_eq("w_stall0", {31'd0, stall},       32'd1);
    chk_eq("w_misal",  {31'd0, misaligned},  32'd0);
    tick();
    chk_eq("w_addr1",  {24'd0, mem_addr},    32'h10);
    chk_eq("w_req1",   {31'd0, mem_req},     32'd1);
    tick();
    chk_eq("w_addr2",  {24'd0, mem_addr},    32'h10);
    chk_eq("w_stall2", {31'd0, stall},       32'd1);
    tick();
    chk_eq("w_addr3",  {24'd0, mem_addr},    32'h10);
    chk_eq("w_stall3", {31'd0, stall},       32'd1);
    mem_ready = 1'b1;
    tick();
    chk_eq("w_addr4",  {24'd0, mem_addr},    32'h11);
    chk_eq("w_stall4", {31'd0, stall},       32'd1);
    tick();
    chk_eq("w_valid5", {31'd0, instr_valid}, 32'd1);
    chk_eq("w_instr",  {16'd0, instr},       32'hC3D4);

    // Address wrap FF -> 00
    mem_model[8'h00] = 8'h34;
    pc = 8'hFF;
    tick();
    chk_eq("wr_addr_hi", {24'd0, mem_addr},    32'hFF);
    chk_eq("wr_instr_hold", {16'd0, instr},    32'hC3D4);
    tick();
    chk_eq("wr_addr_lo", {24'd0, mem_addr},    32'h00);
    tick();
    chk_eq("wr_valid",   {31'd0, instr_valid}, 32'd1);
    chk_eq("wr_instr",   {16'd0, instr},       32'h1234);

    // Redirect 20 -> 40 during LO, with one not-ready cycle first
    pc = 8'h20;
    tick();
    chk_eq("rd_addr20", {24'd0, mem_addr}, 32'h20);
    tick();
    chk_eq("rd_addr21", {24'd0, mem_addr}, 32'h21);
    pc = 8'h40; mem_ready = 1'b0;
    #1;
    chk_eq("rd_stall",  {31'd0, stall},    32'd1);
    tick();
    chk_eq("rd_hold21", {24'd0, mem_addr}, 32'h21);
    chk_eq("rd_holdreq",{31'd0, mem_req},  32'd1);
    mem_ready = 1'b1;
    tick();
    chk_eq("rd_addr40", {24'd0, mem_addr}, 32'h40);
    chk_eq("rd_instr_keep", {16'd0, instr}, 32'h1234);
    tick();
    chk_eq("rd_addr41", {24'd0, mem_addr}, 32'h41);
    tick();
    chk_eq("rd_valid",  {31'd0, instr_valid}, 32'd1);
    chk_eq("rd_instr",  {16'd0, instr},       32'h4748);

    // Reset asserted while in LO for pc=30
    pc = 8'h30;
    tick();
    chk_eq("rl_addr30", {24'd0, mem_addr}, 32'h30);
    tick();
    chk_eq("rl_addr31", {24'd0, mem_addr}, 32'h31);
    reset = 1'b1;
    #1;
    chk_eq("rl_req",   {31'd0, mem_req},     32'd0);
    chk_eq("rl_addr",  {24'd0, mem_addr},    32'h00);
    chk_eq("rl_valid", {31'd0, instr_valid}, 32'd0);
    chk_eq("rl_stall", {31'd0, stall},       32'd1);
    chk_eq("rl_instr", {16'd0, instr},       32'h0000);
    tick();
    reset = 1'b0;
    tick();
    chk_eq("rl_f_addr30", {24'd0, mem_addr}, 32'h30);
    tick();
    chk_eq("rl_f_addr31", {24'd0, mem_addr}, 32'h31);
    tick();
    chk_eq("rl_f_valid",  {31'd0, instr_valid}, 32'd1);
    chk_eq("rl_f_instr",  {16'd0, instr},       32'h393A);

    // Misaligned pc=05
    pc = 8'h05;
    #1;
    chk_eq("ma_flag",  {31'd0, misaligned}, 32'd1);
    tick();
    chk_eq("ma_addr05", {24'd0, mem_addr},  32'h05);
    tick();
    chk_eq("ma_addr06", {24'd0, mem_addr},  32'h06);
    chk_eq("ma_valid2", {31'd0, instr_valid}, 32'd0);
    tick();
    chk_eq("ma_valid3", {31'd0, instr_valid}, 32'd1);
    chk_eq("ma_instr",  {16'd0, instr},       32'h5566);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
